// File: rtl/asic_latrf.sv
// asic_latrf: DEPTH x DW register file built from clk-low transparent latches, with
// flopped write and read stages so every port is posedge-synchronous. Optional macro: ASIC_LATRF_PARITY_EN.
module asic_latrf #(
  parameter int    DW    = 32,
  parameter int    DEPTH = 16,
  parameter string PROP  = "DEFAULT",
  localparam int   AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_perr
);

`ifdef ASIC_LATRF_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif

  logic [DEPTH-1:0] r_en_q;
  logic [DW-1:0]    r_wr_data_q;
  logic [SW-1:0]    w_wr_word;
  logic [SW-1:0]    w_words [DEPTH];

  // r_en_q is the registered one-hot decode of wr_en/wr_addr, i.e. wr_pend & (wr_addr_q == i).
  // It only moves at posedge, while the gate below is forced closed by clk being high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_q      <= '0;
      r_wr_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_en_q[i] <= wr_en && (wr_addr == AW'(i));
      end
      r_wr_data_q <= wr_data;
    end
  end

`ifdef ASIC_LATRF_PARITY_EN
  assign w_wr_word = {^r_wr_data_q, r_wr_data_q};
`else
  assign w_wr_word = r_wr_data_q;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // NOTE: array storage has no reset; contents are undefined until written.
    logic [SW-1:0] r_word;

    if (PROP == "NEGFLOP") begin : g_ff
      // Libraries without usable latches: a negedge flop gives the same read timing.
      always_ff @(negedge clk) begin
        if (r_en_q[i]) r_word <= w_wr_word;
      end
    end else begin : g_lat
      logic w_gate;
      assign w_gate = ~clk & r_en_q[i];
      // NOTE: latch state uses <= like flops, so readers at the closing edge see a stable value.
      always_latch begin
        if (w_gate) r_word <= w_wr_word;
      end
    end

    assign w_words[i] = r_word;
  end

  logic          r_rd_pend;
  logic [AW-1:0] r_rd_addr_q;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic [SW-1:0] w_rd_word;

  // Explicit compare mux: addresses >= DEPTH match no word and read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_rd_addr_q == AW'(i)) w_rd_word = w_words[i];
    end
  end

`ifdef ASIC_LATRF_PARITY_EN
  logic r_rd_perr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend   <= 1'b0;
      r_rd_addr_q <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
`ifdef ASIC_LATRF_PARITY_EN
      r_rd_perr   <= 1'b0;
`endif
    end else begin
      r_rd_pend   <= rd_en;
      r_rd_addr_q <= rd_addr;
      r_rd_valid  <= r_rd_pend;
      if (r_rd_pend) begin
        r_rd_data <= w_rd_word[DW-1:0];
`ifdef ASIC_LATRF_PARITY_EN
        r_rd_perr <= ^w_rd_word;
`endif
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`ifdef ASIC_LATRF_PARITY_EN
  assign rd_perr  = r_rd_perr;
`else
  assign rd_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_asic_latrf.sv
// Self-checking bench for asic_latrf: a DEPTH=16 and a DEPTH=12 instance share one stimulus
// stream; a scoreboard of expected reads is filled at drive time and drained by a negedge monitor.
module tb_asic_latrf;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data16, rd_data12;
  logic          rd_valid16, rd_valid12, rd_perr16, rd_perr12;

  asic_latrf #(.DW(DW), .DEPTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data16), .rd_valid(rd_valid16), .rd_perr(rd_perr16)
  );

  asic_latrf #(.DW(DW), .DEPTH(12)) u_dut12 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data12), .rd_valid(rd_valid12), .rd_perr(rd_perr12)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] d16;
    bit            v16;
    bit            p16;
    logic [DW-1:0] d12;
    bit            v12;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] m_mem [16];
  bit            m_vld [16];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: reads are due two posedges after the negedge they were driven on.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (rd_data16 !== '0 || rd_valid16 !== 1'b0 || rd_perr16 !== 1'b0 ||
          rd_data12 !== '0 || rd_valid12 !== 1'b0 || rd_perr12 !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got d16=%h v16=%b p16=%b d12=%h v12=%b p12=%b, expected all 0",
                 rd_data16, rd_valid16, rd_perr16, rd_data12, rd_valid12, rd_perr12);
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (rd_valid16 !== 1'b1 || rd_valid12 !== 1'b1) begin
        errors++;
        $display("FAIL rd_valid_pulse @%0d: got v16=%b v12=%b, expected 1", cyc, rd_valid16, rd_valid12);
      end
      if (mon_e.v16) begin
        checks++;
        if (rd_data16 !== mon_e.d16 || rd_perr16 !== mon_e.p16) begin
          errors++;
          $display("FAIL rd_data16 @%0d: got %h perr=%b, expected %h perr=%b",
                   cyc, rd_data16, rd_perr16, mon_e.d16, mon_e.p16);
        end
      end
      if (mon_e.v12) begin
        checks++;
        if (rd_data12 !== mon_e.d12 || rd_perr12 !== 1'b0) begin
          errors++;
          $display("FAIL rd_data12 @%0d: got %h perr=%b, expected %h perr=0",
                   cyc, rd_data12, rd_perr12, mon_e.d12);
        end
      end
    end else begin
      checks++;
      if (rd_valid16 !== 1'b0 || rd_valid12 !== 1'b0) begin
        errors++;
        $display("FAIL rd_valid_idle @%0d: got v16=%b v12=%b, expected 0", cyc, rd_valid16, rd_valid12);
      end
    end
  end

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  // Drives one cycle at a negedge; the write is applied to the model before the read is
  // predicted, so a same-cycle read of the written address expects the new data.
  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input bit re, input int ra);
    exp_t e;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_en = re; rd_addr = AW'(ra);
    if (we) begin
      m_mem[wa] = wd;
      m_vld[wa] = 1'b1;
    end
    if (re) begin
      e.due = cyc + 2;
      e.d16 = m_mem[ra];
      e.v16 = m_vld[ra];
      e.p16 = 1'b0;
      e.d12 = (ra < 12) ? m_mem[ra] : '0;
      e.v12 = (ra < 12) ? m_vld[ra] : 1'b1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_data16 !== '0 || rd_valid16 !== 1'b0 || rd_perr16 !== 1'b0) begin
      errors++;
      $display("FAIL test_reset: got d=%h v=%b p=%b, expected 0", rd_data16, rd_valid16, rd_perr16);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid16 !== 1'b0 || rd_data16 !== '0) begin
      errors++;
      $display("FAIL test_reset_release: got d=%h v=%b, expected 0", rd_data16, rd_valid16);
    end
  endtask

  task automatic test_seq();
    for (int i = 0; i < 16; i++) drive(1, i, 32'hA5A5_0001 + DW'(i), 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, '0, 1, i);
    drain(3);
  endtask

  task automatic test_write_through();
    drive(1, 3, 32'hDEAD_BEEF, 1, 3);
    drive(1, 4, 32'hCAFE_0004, 0, 0);
    drive(0, 0, '0, 1, 4);
    drain(3);
  endtask

  task automatic test_back_to_back();
    drive(1, 7, 32'h7777_0001, 0, 0);
    drive(1, 7, 32'h7777_0002, 1, 7);
    drive(1, 8, 32'h8888_0001, 1, 7);
    drive(1, 9, 32'h9999_0001, 1, 8);
    drive(0, 0, '0, 1, 9);
    drain(3);
  endtask

  task automatic test_out_of_range();
    drive(1, 13, 32'hFFFF_FFFF, 0, 0);
    drive(0, 0, '0, 1, 13);
    for (int i = 0; i < 12; i++) drive(0, 0, '0, 1, i);
    drain(3);
  endtask

  task automatic test_reset_mid_op();
    drive(1, 5, 32'h1234_5678, 0, 0);
    drive(0, 0, '0, 1, 5);
    idle_inputs();
    #2 reset = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_valid16 !== 1'b0 || rd_valid12 !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_read: got v16=%b v12=%b, expected 0", rd_valid16, rd_valid12);
    end
    reset = 1'b0;
    @(negedge clk);
    drive(0, 0, '0, 1, 5);
    drain(3);
    // Reset lands in the open low phase of the addr-6 write: word 6 becomes undefined.
    drive(1, 6, 32'h6666_6666, 0, 0);
    idle_inputs();
    #2 reset = 1'b1;
    m_vld[6] = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) drive(0, 0, '0, 1, i);
    drain(3);
  endtask

  task automatic test_parity();
`ifdef ASIC_LATRF_PARITY_EN
    exp_t e;
    drive(1, 2, 32'h0000_0001, 0, 0);
    drive(0, 0, '0, 1, 2);
    drain(3);
    force u_dut16.g_word[2].r_word = {1'b1, 32'h0000_0000};
    drive(0, 0, '0, 1, 2);
    e = sb.pop_back();
    e.d16 = '0;
    e.p16 = 1'b1;
    sb.push_back(e);
    drain(3);
    release u_dut16.g_word[2].r_word;
    drive(1, 2, 32'h0000_0002, 0, 0);
    drive(0, 0, '0, 1, 2);
    drain(3);
`else
    drive(1, 2, 32'h0000_0001, 1, 2);
    drain(3);
    checks++;
    if (rd_perr16 !== 1'b0 || rd_perr12 !== 1'b0) begin
      errors++;
      $display("FAIL parity_off: got p16=%b p12=%b, expected 0", rd_perr16, rd_perr12);
    end
`endif
  endtask

  task automatic test_random(input int n);
    int wa, ra;
    bit we, re;
    for (int i = 0; i < n; i++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 55);
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      drive(we, wa, $urandom, re, ra);
    end
    drain(4);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 1'b0;
    end
    test_reset();
    test_seq();
    test_write_through();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_op();
    test_parity();
    test_random(10000);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
